muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit. It consumes the two register-file read operands (readData1/readData2) for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, computes over a fixed multi-cycle schedule, and returns the result to the register file write port (writeRegId/writeData/regWrite). The pipeline front end issues one operation at a time via a start/busy handshake.

## Interface

- WIDTH, 32, operand/result width; the test plan values assume 32.
- clock  in  1  rising-edge clock.
- resetN  in  1  asynchronous active-low reset.
- start  in  1  issue request; sampled only in IDLE.
- flush  in  1  cancel in-flight operation.
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operandA  in  WIDTH  rs1 value (readData1).
- operandB  in  WIDTH  rs2 value (readData2).
- destReg  in  5  rd index.
- busy  out  1  operation in flight; start ignored.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  writeData; holds until the next done.
- writeRegId  out  5  rd latched at start.
- regWrite  out  1  equals done && writeRegId != 0.

## Operation

- States: IDLE, PREP, CALC, FIN. 6-bit iteration counter.
- IDLE: on start && !flush, latch op, operands, and destReg. Go to PREP.
- PREP:
  - Take magnitudes of operands by signedness: MULH, DIV, and REM treat both as signed. MULHSU treats A as signed, B as unsigned. MUL and unsigned ops take operands raw.
  - Record result sign. Detect special cases: B == 0 for divides, and A == 0x80000000 && B == 0xFFFFFFFF for signed DIV/REM.
  - Clear the counter and go to CALC.
- CALC:
  - Multiply: one shift-add step per cycle into a 2·WIDTH accumulator.
  - Divide: one restoring shift-subtract step per cycle.
  - Go to FIN after WIDTH steps (counter == WIDTH-1).
- FIN: apply the sign fix and select the output.
  - MUL: low word. MULH*: high word.
  - DIV*: quotient. REM*: remainder.
  - Forced results:
    - divide by zero: quotient 0xFFFFFFFF, remainder = A.
    - signed overflow: quotient 0x80000000, remainder 0.
  - Register result, pulse done, and return to IDLE.
- flush in PREP, CALC, or FIN: go to IDLE at the next edge. No done or regWrite. result keeps its previous value.
- flush and start together in IDLE: flush wins; nothing is issued.
- start while busy: ignored, with no queuing.

## Timing

- Reset: state IDLE; busy, done, regWrite = 0; result = 0; writeRegId = 0.
- resetN asserted mid-operation: immediate abort to the reset values.
- Schedule for a start sampled at edge E0:
  - busy = 1 after E0.
  - PREP runs through E1.
  - CALC runs on E2..E(WIDTH+1).
  - FIN at E(WIDTH+2), which registers result and sets done = regWrite = 1 for exactly one cycle. busy = 0 after the same edge.
  - Latency for WIDTH = 32: 34 cycles.
- Back-to-back operation: start may be asserted in the done cycle, because state is already IDLE, so it is accepted on the next edge.
- Operands and destReg are captured at E0; the inputs may change afterwards.

## Configuration

- MULDIV_EARLY_OUT_EN defined: divide-by-zero and signed overflow skip CALC and go PREP→FIN. done follows E2, a 2-cycle latency.
- MULDIV_EARLY_OUT_EN undefined: every operation takes the full 34 cycles. Forced results are identical in both builds.

## Structure

- Package muldiv_pkg:
  - op encoding localparams (OP_MUL…OP_REMU);
  - state encoding (ST_IDLE, ST_PREP, ST_CALC, ST_FIN);
  - constants for the forced results.
- One sub-module, muldiv_datapath:
  - contents: accumulator/quotient/remainder shift registers, per-cycle add/subtract step, sign fix;
  - step control: driven by the top-level FSM via prep/step/finish strobes.
- FSM and handshake stay in muldiv_unit.

## Test plan

- MUL, A = 7, B = 0xFFFFFFFD (−3), destReg = 5 → result = 0xFFFFFFEB. done, regWrite, and writeRegId = 5 appear exactly 34 cycles after start; busy is high in between.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Special cases:
  - DIV 100 / 0 → 0xFFFFFFFF; REM 100 / 0 → 0x64.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - Latency is 2 cycles with MULDIV_EARLY_OUT_EN and 34 without.
- Handshake and abort:
  - start pulsed mid-CALC → ignored; the original result appears on schedule.
  - flush at cycle 10 → busy = 0 next cycle, with no done or regWrite.
  - resetN low mid-CALC → all outputs 0 immediately.
- destReg = 0 with MUL 3 × 4 → done pulses with result = 12, and regWrite stays 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding and the forced results for divide-by-zero / signed overflow.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // INT_MIN doubles as the overflow dividend pattern and the overflow quotient.
  localparam logic [XLEN-1:0] INT_MIN       = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] DIV0_QUOTIENT = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] OVF_REMAINDER = {XLEN{1'b0}};

endpackage

// File: rtl/muldiv_datapath.sv
// Operand capture, magnitude/sign preparation, shift-add / restoring shift-subtract
// iteration and final sign fix. MULDIV_EARLY_OUT_EN enables the special-case early_out flag.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             load,
  input  logic             prep,
  input  logic             step,
  input  logic             finish,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             early_out,
  output logic [WIDTH-1:0] result
);

  function automatic logic [WIDTH-1:0] fix_w(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_2w(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]        mcand_q, mcand_d;
  logic [2*WIDTH-1:0]      acc_q, acc_d;
  logic                    neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic                    div0_q, div0_d, ovf_q, ovf_d;
  logic [WIDTH-1:0]        result_q, result_d;

  logic                    a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
  logic [WIDTH:0]          mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]      prod;
  logic [WIDTH-1:0]        quo, rem, sel;

  always_comb begin
    a_sgn = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_sgn = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg = a_sgn && a_q[WIDTH-1];
    b_neg = b_sgn && b_q[WIDTH-1];
    div0  = op[2] && (b_q == '0);
    ovf   = ((op == OP_DIV) || (op == OP_REM)) && (a_q == WIDTH'(INT_MIN)) && (b_q == '1);

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mcand_q};

    prod = fix_2w(neg_q, acc_q);
    quo  = fix_w(neg_q, acc_q[WIDTH-1:0]);
    rem  = fix_w(neg_rem_q, acc_q[2*WIDTH-1:WIDTH]);

    case (op)
      OP_MUL:                   sel = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU,
      OP_MULHU:                 sel = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:          sel = div0 ? WIDTH'(DIV0_QUOTIENT) : (ovf ? WIDTH'(INT_MIN) : quo);
      default:                  sel = div0 ? a_q : (ovf ? WIDTH'(OVF_REMAINDER) : rem);
    endcase
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    result_d  = result_q;

    if (load) begin
      a_d = operand_a;
      b_d = operand_b;
    end
    if (prep) begin
      acc_d     = {{WIDTH{1'b0}}, fix_w(a_neg, a_q)};
      mcand_d   = fix_w(b_neg, b_q);
      neg_d     = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      div0_d    = div0;
      ovf_d     = ovf;
    end
    if (step) begin
      if (op[2]) begin
        if (div_diff[WIDTH]) acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else                 acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
    end
    if (finish) result_d = sel;
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = div0 | ovf;
`else
  assign early_out = 1'b0;
`endif

  // iteration registers
  always_ff @(posedge clock) begin
    a_q       <= a_d;
    b_q       <= b_d;
    mcand_q   <= mcand_d;
    acc_q     <= acc_d;
    neg_q     <= neg_d;
    neg_rem_q <= neg_rem_d;
    div0_q    <= div0_d;
    ovf_q     <= ovf_d;
  end

  // architectural result
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) result_q <= '0;
    else         result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: start/busy handshake, IDLE/PREP/CALC/FIN FSM and
// register-file write-back. MULDIV_EARLY_OUT_EN lets special divides skip CALC.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [4:0]       destReg,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       writeRegId,
  output logic             regWrite
);

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [4:0] rd_q, rd_d;
  logic       done_q, done_d;
  logic       load, prep, step, finish, early_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    load    = 1'b0;
    prep    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          load    = 1'b1;
          op_d    = op;
          rd_d    = destReg;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        prep    = 1'b1;
        cnt_d   = '0;
        state_d = early_out ? ST_FIN : ST_CALC;
      end
      ST_CALC: begin
        step = 1'b1;
        if (cnt_q == LAST_STEP) state_d = ST_FIN;
        else                    cnt_d   = cnt_q + 6'd1;
      end
      ST_FIN: begin
        finish  = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush abandons the operation without touching the architectural result.
    if (flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      finish  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock     (clock),
    .resetN    (resetN),
    .load      (load),
    .prep      (prep),
    .step      (step),
    .finish    (finish),
    .op        (op_q),
    .operand_a (operandA),
    .operand_b (operandB),
    .early_out (early_out),
    .result    (result)
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign writeRegId = rd_q;
  assign regWrite   = done_q && (rd_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic vectors, special cases,
// latency, handshake, flush and asynchronous reset abort.
module tb_muldiv_unit;

  localparam logic [2:0] T_MUL = 3'b000, T_MULH = 3'b001, T_MULHSU = 3'b010, T_MULHU = 3'b011;
  localparam logic [2:0] T_DIV = 3'b100, T_DIVU = 3'b101, T_REM = 3'b110, T_REMU = 3'b111;
  localparam int FULL_LAT = 34;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 34;
`endif

  logic        clock = 1'b0;
  logic        resetN = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic [4:0]  destReg = '0;
  logic        busy, done, regWrite;
  logic [31:0] result;
  logic [4:0]  writeRegId;

  int checks = 0;
  int passed = 0;

  logic [31:0] r1, r2;
  int          l1, l2;
  logic        w1;
  logic [4:0]  id1;
  logic        bok;

  muldiv_unit dut (
    .clock      (clock),
    .resetN     (resetN),
    .start      (start),
    .flush      (flush),
    .op         (op),
    .operandA   (operandA),
    .operandB   (operandB),
    .destReg    (destReg),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .writeRegId (writeRegId),
    .regWrite   (regWrite)
  );

  always #5 clock = ~clock;

  // Issues one op and waits (bounded) for done; entered and left at posedge+1.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output int lat,
                        output logic rw, output logic [4:0] wid, output logic busy_ok);
    op = o; operandA = a; operandB = b; destReg = rd; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; operandA = 32'hDEADBEEF; operandB = 32'h12345678; destReg = 5'h1f; op = 3'b111;
    lat = 0; busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    res = result; rw = regWrite; wid = writeRegId;
  endtask

  task automatic test_reset;
    #2 resetN = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (regWrite !== 1'b0) $display("FAIL reset_regwrite got %b want 0", regWrite); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL reset_result got %h want 0", result); else passed++;
    checks++; if (writeRegId !== 5'd0) $display("FAIL reset_wid got %0d want 0", writeRegId); else passed++;
    resetN = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_mul;
    run_op(T_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, r1, l1, w1, id1, bok);
    checks++; if (r1 !== 32'hFFFFFFEB) $display("FAIL mul_result got %h want ffffffeb", r1); else passed++;
    checks++; if (l1 != FULL_LAT) $display("FAIL mul_latency got %0d want %0d", l1, FULL_LAT); else passed++;
    checks++; if (w1 !== 1'b1) $display("FAIL mul_regwrite got %b want 1", w1); else passed++;
    checks++; if (id1 !== 5'd5) $display("FAIL mul_wid got %0d want 5", id1); else passed++;
    checks++; if (bok !== 1'b1) $display("FAIL mul_busy_between got %b want 1", bok); else passed++;
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) $display("FAIL mul_done_pulse got %b want 0", done); else passed++;
    checks++; if (regWrite !== 1'b0) $display("FAIL mul_regwrite_pulse got %b want 0", regWrite); else passed++;
    checks++; if (result !== 32'hFFFFFFEB) $display("FAIL mul_result_hold got %h want ffffffeb", result); else passed++;
  endtask

  task automatic test_mulh;
    run_op(T_MULH, 32'h80000000, 32'h80000000, 5'd1, r1, l1, w1, id1, bok);
    checks++; if (r1 !== 32'h40000000) $display("FAIL mulh got %h want 40000000", r1); else passed++;
    run_op(T_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, r1, l1, w1, id1, bok);
    checks++; if (r1 !== 32'hFFFFFFFE) $display("FAIL mulhu got %h want fffffffe", r1); else passed++;
    run_op(T_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, r1, l1, w1, id1, bok);
    checks++; if (r1 !== 32'hFFFFFFFF) $display("FAIL mulhsu got %h want ffffffff", r1); else passed++;
  endtask

  task automatic test_div;
    run_op(T_DIV, 32'hFFFFFFF9, 32'd2, 5'd4, r1, l1, w1, id1, bok);
    checks++; if (r1 !== 32'hFFFFFFFD) $display("FAIL div_neg got %h want fffffffd", r1); else passed++;
    run_op(T_REM, 32'hFFFFFFF9, 32'd2, 5'd4, r1, l1, w1, id1, bok);
    checks++; if (r1 !== 32'hFFFFFFFF) $display("FAIL rem_neg got %h want ffffffff", r1); else passed++;
    run_op(T_DIVU, 32'd100, 32'd7, 5'd6, r1, l1, w1, id1, bok);
    checks++; if (r1 !== 32'd14) $display("FAIL divu got %h want 0000000e", r1); else passed++;
    checks++; if (l1 != FULL_LAT) $display("FAIL divu_latency got %0d want %0d", l1, FULL_LAT); else passed++;
    run_op(T_REMU, 32'd100, 32'd7, 5'd6, r1, l1, w1, id1, bok);
    checks++; if (r1 !== 32'd2) $display("FAIL remu got %h want 00000002", r1); else passed++;
  endtask

  task automatic test_special;
    run_op(T_DIV, 32'd100, 32'd0, 5'd7, r1, l1, w1, id1, bok);
    checks++; if (r1 !== 32'hFFFFFFFF) $display("FAIL div0_quo got %h want ffffffff", r1); else passed++;
    checks++; if (l1 != SPECIAL_LAT) $display("FAIL div0_latency got %0d want %0d", l1, SPECIAL_LAT); else passed++;
    run_op(T_REM, 32'd100, 32'd0, 5'd7, r1, l1, w1, id1, bok);
    checks++; if (r1 !== 32'h64) $display("FAIL div0_rem got %h want 00000064", r1); else passed++;
    run_op(T_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd8, r1, l1, w1, id1, bok);
    checks++; if (r1 !== 32'h80000000) $display("FAIL ovf_quo got %h want 80000000", r1); else passed++;
    checks++; if (l1 != SPECIAL_LAT) $display("FAIL ovf_latency got %0d want %0d", l1, SPECIAL_LAT); else passed++;
    run_op(T_REM, 32'h80000000, 32'hFFFFFFFF, 5'd8, r1, l1, w1, id1, bok);
    checks++; if (r1 !== 32'h0) $display("FAIL ovf_rem got %h want 00000000", r1); else passed++;
  endtask

  task automatic test_back_to_back;
    run_op(T_DIVU, 32'd100, 32'd7, 5'd9, r1, l1, w1, id1, bok);
    run_op(T_REMU, 32'd100, 32'd7, 5'd10, r2, l2, w1, id1, bok);
    checks++; if (r1 !== 32'd14) $display("FAIL b2b_first got %h want 0000000e", r1); else passed++;
    checks++; if (r2 !== 32'd2) $display("FAIL b2b_second got %h want 00000002", r2); else passed++;
    checks++; if (l2 != FULL_LAT) $display("FAIL b2b_latency got %0d want %0d", l2, FULL_LAT); else passed++;
    checks++; if (id1 !== 5'd10) $display("FAIL b2b_wid got %0d want 10", id1); else passed++;
  endtask

  task automatic test_start_ignored;
    int n;
    op = T_MUL; operandA = 32'd7; operandB = 32'hFFFFFFFD; destReg = 5'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (n == 10) begin
        op = T_DIVU; operandA = 32'd100; operandB = 32'd7; destReg = 5'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    checks++; if (result !== 32'hFFFFFFEB) $display("FAIL ignore_result got %h want ffffffeb", result); else passed++;
    checks++; if (n != FULL_LAT) $display("FAIL ignore_latency got %0d want %0d", n, FULL_LAT); else passed++;
    checks++; if (writeRegId !== 5'd5) $display("FAIL ignore_wid got %0d want 5", writeRegId); else passed++;
    repeat (3) begin @(posedge clock); #1; end
    checks++; if (busy !== 1'b0) $display("FAIL ignore_no_queue got busy %b want 0", busy); else passed++;
  endtask

  task automatic test_flush;
    logic saw_done;
    op = T_DIVU; operandA = 32'd100; operandB = 32'd7; destReg = 5'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL flush_done got %b want 0", done); else passed++;
    checks++; if (regWrite !== 1'b0) $display("FAIL flush_regwrite got %b want 0", regWrite); else passed++;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done || regWrite || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) $display("FAIL flush_quiet got %b want 0", saw_done); else passed++;
    checks++; if (result !== 32'hFFFFFFEB) $display("FAIL flush_result_kept got %h want ffffffeb", result); else passed++;
  endtask

  task automatic test_flush_start;
    op = T_MUL; operandA = 32'd2; operandB = 32'd2; destReg = 5'd4; start = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL flush_start_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid;
    op = T_MUL; operandA = 32'd7; operandB = 32'hFFFFFFFD; destReg = 5'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    #2 resetN = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL areset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL areset_done got %b want 0", done); else passed++;
    checks++; if (regWrite !== 1'b0) $display("FAIL areset_regwrite got %b want 0", regWrite); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL areset_result got %h want 0", result); else passed++;
    checks++; if (writeRegId !== 5'd0) $display("FAIL areset_wid got %0d want 0", writeRegId); else passed++;
    @(posedge clock); #1;
    resetN = 1'b1;
    repeat (30) begin @(posedge clock); #1; end
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL areset_aborted got busy %b done %b want 0 0", busy, done); else passed++;
  endtask

  task automatic test_rd_zero;
    run_op(T_MUL, 32'd3, 32'd4, 5'd0, r1, l1, w1, id1, bok);
    checks++; if (r1 !== 32'd12) $display("FAIL rd0_result got %h want 0000000c", r1); else passed++;
    checks++; if (l1 != FULL_LAT) $display("FAIL rd0_done_latency got %0d want %0d", l1, FULL_LAT); else passed++;
    checks++; if (w1 !== 1'b0) $display("FAIL rd0_regwrite got %b want 0", w1); else passed++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_back_to_back();
    test_start_ignored();
    test_flush();
    test_flush_start();
    test_reset_mid();
    test_rd_zero();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
